multicycle_cu: RTL
==================

Name: multicycle_cu

Overview:
- Multi-cycle control unit for the same 14-instruction ISA as the single-cycle datapath.
- Sequences each instruction through IF/ID/EXE/MEM/WB states.
- Drives the shared datapath strobes (PCWre, IRWre, RegWre, mRD, mWR) one phase at a time.
- Handshakes with a variable-latency data memory via mem_ready.

Parameters:
- OP_W, 6, opcode width.
- CNT_W, 32, width of retired-instruction counter (used only with PERF_CNT_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- opCode  in  OP_W  opcode from IR; stable from ID onward.
- zero  in  1  ALU zero flag, valid in EXE.
- mem_ready  in  1  data memory done; sampled in MEM.
- IRWre  out  1  IR load strobe.
- PCWre  out  1  PC update strobe.
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target.
- RegDst  out  1  0 = rt, 1 = rd.
- RegWre  out  1  register file write strobe.
- ALUSrcA  out  1  1 = shamt (sll).
- ALUSrcB  out  1  1 = extended immediate.
- ALUOp  out  3  ALU function.
- ExtSel  out  1  0 = zero-extend (ori), 1 = sign-extend.
- mRD  out  1  data memory read request.
- mWR  out  1  data memory write request.
- DBDataSrc  out  1  1 = memory data to register file.
- state  out  3  current state encoding.
- halted  out  1  high in HALT.

Behaviour:
- Opcodes:
  - add 000000, addi 000001, sub 000010.
  - ori 010000, and 010001, or 010010.
  - sll 011000, slti 011011.
  - sw 100110, lw 100111.
  - beq 110000, bne 110001.
  - j 111000, halt 111111.
  - Any other opcode is a NOP.
- State register: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111.
- Reset (async, any time, including mid-MEM): state := IF.
  - While Reset is high, all strobes (IRWre, PCWre, RegWre, mRD, mWR) are forced 0 and halted=0.
  - First IF cycle starts on the first edge after Reset deasserts.
- Steering outputs are pure combinational decode of opCode in every state:
  - ALUSrcA: sll.
  - ALUSrcB: addi/ori/slti/sw/lw.
  - RegDst=0: addi/ori/slti/lw.
  - ExtSel=0: ori only.
  - DBDataSrc: lw.
  - ALUOp:
    - 000: add/addi/sw/lw/other.
    - 001: sub/beq/bne.
    - 010: sll.
    - 011: ori/or.
    - 100: and.
    - 110: slti.
- Strobes are combinational from state, opCode, zero and mem_ready; they are 0 unless listed below.
- IF: IRWre=1; next state ID.
- ID:
  - j: PCWre=1, PCSrc=10, next IF.
  - halt: next HALT.
  - Unknown opcode: PCWre=1, PCSrc=00, next IF.
  - Otherwise: next EXE.
- EXE:
  - beq/bne: PCWre=1; PCSrc=01 if (beq && zero) or (bne && !zero), else 00; next IF.
  - sw/lw: next MEM.
  - Others: next WB.
- MEM:
  - lw: mRD=1 held while mem_ready=0. On a cycle with mem_ready=1, next state WB.
  - sw: mWR=1 held while mem_ready=0. On a cycle with mem_ready=1, PCWre=1, PCSrc=00, next IF.
  - mem_ready=0: stay in MEM indefinitely; no timeout.
- WB: RegWre=1, PCWre=1, PCSrc=00; next IF.
- HALT: all strobes 0, halted=1; stays until Reset.
- PCSrc is 00 whenever PCWre=0.
- Latency with mem_ready tied high:
  - j / NOP: 2 cycles.
  - beq/bne: 3 cycles.
  - ALU ops and sw: 4 cycles.
  - lw: 5 cycles.
- Exactly one PCWre pulse per retired instruction. RegWre is never asserted in the same state as mWR.

Optional Feature:
- Macro: MULTICYCLE_CU_PERF_CNT_EN.
- When defined:
  - Adds output retired [CNT_W-1:0], reset to 0.
  - Increments by 1 on each rising edge where PCWre=1.
  - Wraps modulo 2^CNT_W.
  - Frozen in HALT.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset high 2 cycles, release, opCode=000000 (add), mem_ready=1 -> state 000,001,010,100,000. IRWre=1 in cycle 0; RegWre=1 and PCWre=1 only in cycle 3; RegDst=1, ALUOp=000.
- beq 110000 with zero=1 in EXE -> PCWre=1, PCSrc=01 in cycle 2. Repeat with zero=0 -> PCSrc=00. bne with zero=0 -> PCSrc=01.
- lw 100111, mem_ready low 3 MEM cycles then high -> mRD=1 for 4 cycles, then WB with RegWre=1, DBDataSrc=1, RegDst=0. Total 8 cycles.
- sw 100110 with mem_ready=1 -> mWR=1 and PCWre=1 in the same MEM cycle, RegWre never 1. Assert Reset mid-MEM on a second sw -> mWR drops immediately, state=000.
- j 111000 -> PCWre=1, PCSrc=10 in ID, 2-cycle instruction. Opcode 101010 -> NOP, PCSrc=00. halt 111111 -> state 111, halted=1, no strobes for 20 cycles until Reset.
- With MULTICYCLE_CU_PERF_CNT_EN and CNT_W=4: 17 add instructions -> retired=1. Counter holds during HALT.

Source files
------------

// File: rtl/multicycle_cu_if.sv
// Control-unit <-> datapath bundle for the multi-cycle CPU.
// master: control unit (drives strobes/steering); slave: datapath side.
interface multicycle_cu_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] opCode;
  logic            zero;
  logic            mem_ready;
  logic            IRWre;
  logic            PCWre;
  logic [1:0]      PCSrc;
  logic            RegDst;
  logic            RegWre;
  logic            ALUSrcA;
  logic            ALUSrcB;
  logic [2:0]      ALUOp;
  logic            ExtSel;
  logic            mRD;
  logic            mWR;
  logic            DBDataSrc;
  logic [2:0]      state;
  logic            halted;

  modport master (
    input  opCode, zero, mem_ready,
    output IRWre, PCWre, PCSrc, RegDst, RegWre, ALUSrcA, ALUSrcB, ALUOp,
           ExtSel, mRD, mWR, DBDataSrc, state, halted
  );

  modport slave (
    output opCode, zero, mem_ready,
    input  IRWre, PCWre, PCSrc, RegDst, RegWre, ALUSrcA, ALUSrcB, ALUOp,
           ExtSel, mRD, mWR, DBDataSrc, state, halted
  );
endinterface

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencer for the 14-op ISA.
// Optional retired-instruction counter: define MULTICYCLE_CU_PERF_CNT_EN.
module multicycle_cu #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  multicycle_cu_if.master   bus
`ifdef MULTICYCLE_CU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired
`endif
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b011000);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b011011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

  state_t r_state, w_next;

  logic w_add, w_addi, w_sub, w_ori, w_and, w_or, w_sll, w_slti;
  logic w_sw, w_lw, w_beq, w_bne, w_j, w_halt, w_known;
  logic       w_irwre, w_pcwre, w_regwre, w_mrd, w_mwr;
  logic [1:0] w_pcsrc;

  assign w_add   = (bus.opCode == OP_ADD);
  assign w_addi  = (bus.opCode == OP_ADDI);
  assign w_sub   = (bus.opCode == OP_SUB);
  assign w_ori   = (bus.opCode == OP_ORI);
  assign w_and   = (bus.opCode == OP_AND);
  assign w_or    = (bus.opCode == OP_OR);
  assign w_sll   = (bus.opCode == OP_SLL);
  assign w_slti  = (bus.opCode == OP_SLTI);
  assign w_sw    = (bus.opCode == OP_SW);
  assign w_lw    = (bus.opCode == OP_LW);
  assign w_beq   = (bus.opCode == OP_BEQ);
  assign w_bne   = (bus.opCode == OP_BNE);
  assign w_j     = (bus.opCode == OP_J);
  assign w_halt  = (bus.opCode == OP_HALT);
  assign w_known = w_add | w_addi | w_sub | w_ori | w_and | w_or | w_sll |
                   w_slti | w_sw | w_lw | w_beq | w_bne | w_j | w_halt;

  // Steering: pure decode of the opcode, independent of state.
  assign bus.ALUSrcA   = w_sll;
  assign bus.ALUSrcB   = w_addi | w_ori | w_slti | w_sw | w_lw;
  assign bus.RegDst    = ~(w_addi | w_ori | w_slti | w_lw);
  assign bus.ExtSel    = ~w_ori;
  assign bus.DBDataSrc = w_lw;
  assign bus.ALUOp     = w_sll               ? 3'b010 :
                         (w_ori | w_or)      ? 3'b011 :
                         w_and               ? 3'b100 :
                         w_slti              ? 3'b110 :
                         (w_sub | w_beq | w_bne) ? 3'b001 : 3'b000;

  // State register; async reset parks the sequencer in IF.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

  // Next-state and phase strobes.
  always_comb begin
    w_next   = r_state;
    w_irwre  = 1'b0;
    w_pcwre  = 1'b0;
    w_pcsrc  = 2'b00;
    w_regwre = 1'b0;
    w_mrd    = 1'b0;
    w_mwr    = 1'b0;
    case (r_state)
      S_IF: begin
        w_irwre = 1'b1;
        w_next  = S_ID;
      end
      S_ID: begin
        if (w_j) begin
          w_pcwre = 1'b1;
          w_pcsrc = 2'b10;
          w_next  = S_IF;
        end else if (w_halt) begin
          w_next  = S_HALT;
        end else if (!w_known) begin
          w_pcwre = 1'b1;        // NOP retires straight from ID
          w_next  = S_IF;
        end else begin
          w_next  = S_EXE;
        end
      end
      S_EXE: begin
        if (w_beq | w_bne) begin
          w_pcwre = 1'b1;
          w_pcsrc = ((w_beq & bus.zero) | (w_bne & ~bus.zero)) ? 2'b01 : 2'b00;
          w_next  = S_IF;
        end else if (w_sw | w_lw) begin
          w_next  = S_MEM;
        end else begin
          w_next  = S_WB;
        end
      end
      S_MEM: begin
        // Request held for the whole access, including the ready cycle.
        if (w_lw) begin
          w_mrd = 1'b1;
          if (bus.mem_ready) w_next = S_WB;
        end else if (w_sw) begin
          w_mwr = 1'b1;
          if (bus.mem_ready) begin
            w_pcwre = 1'b1;
            w_next  = S_IF;
          end
        end else begin
          // Unreachable with a stable opcode; retire to keep one PC pulse.
          w_pcwre = 1'b1;
          w_next  = S_IF;
        end
      end
      S_WB: begin
        w_regwre = 1'b1;
        w_pcwre  = 1'b1;
        w_next   = S_IF;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  // Strobes are suppressed for as long as reset is held.
  assign bus.IRWre  = w_irwre  & ~Reset;
  assign bus.PCWre  = w_pcwre  & ~Reset;
  assign bus.PCSrc  = w_pcsrc  & {2{~Reset}};
  assign bus.RegWre = w_regwre & ~Reset;
  assign bus.mRD    = w_mrd    & ~Reset;
  assign bus.mWR    = w_mwr    & ~Reset;
  assign bus.state  = r_state;
  assign bus.halted = (r_state == S_HALT) & ~Reset;

`ifdef MULTICYCLE_CU_PERF_CNT_EN
  // Retired-instruction count: one PC update per instruction; wraps naturally.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)        retired <= '0;
    else if (w_pcwre) retired <= retired + 1'b1;
  end
`endif

endmodule
